// File: rtl/ddr_tx_pkg.sv
// Shared types and constants for the DDR transmit framer and its receive-side counterpart.
package ddr_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        DATA,
        PARITY,
        TAIL
    } tx_state_e;

    localparam int unsigned PAIR_BITS         = 2;
    localparam int unsigned WARMUP_CYCLES_DEF = 4;
    localparam int unsigned TAIL_CYCLES_DEF   = 2;

endpackage

// File: rtl/ddr_tx_shifter.sv
// Word shift register, pair counter and (with DDR_TX_FRAMER_PARITY_EN) parity accumulator.
// d0/d1 present the pair that an emit on this edge sends out.
module ddr_tx_shifter
    import ddr_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              emit,
    input  logic [DATA_W-1:0] load_data,
    output logic              d0,
    output logic              d1,
`ifdef DDR_TX_FRAMER_PARITY_EN
    output logic              parity,
`endif
    output logic              pair_last
);

    localparam int unsigned PAIRS = DATA_W / PAIR_BITS;
    localparam int unsigned CNT_W = $clog2(PAIRS + 1);

    logic [DATA_W-1:0] sr_q, sr_d, src;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // load+emit is the seamless hand-over: the new word's first pair leaves immediately.
    always_comb begin
        src   = load ? load_data : sr_q;
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (emit) begin
            sr_d  = src >> PAIR_BITS;
            cnt_d = load ? CNT_W'(1) : cnt_q + 1'b1;
        end else if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end
    end

    assign d0        = src[0];
    assign d1        = src[1];
    assign pair_last = (cnt_q == CNT_W'(PAIRS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef DDR_TX_FRAMER_PARITY_EN
    logic par_q, par_d;

    // A load without emit only happens on frame start, which is where parity restarts.
    always_comb begin
        par_d = par_q;
        if (emit) begin
            par_d = par_q ^ src[0] ^ src[1];
        end else if (load) begin
            par_d = 1'b0;
        end
    end

    assign parity = par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: rtl/ddr_tx_framer.sv
// Stream-to-ODDR framer: warm-up toggle, LSB-first bit pairs, optional parity pair
// (DDR_TX_FRAMER_PARITY_EN), quiet tail, then pin release via oen.
module ddr_tx_framer
    import ddr_tx_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned WARMUP_CYCLES = WARMUP_CYCLES_DEF,
    parameter int unsigned TAIL_CYCLES   = TAIL_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              d0,
    output logic              d1,
    output logic              oen,
    output logic              busy,
    output logic              err_underrun
);

    localparam int unsigned PH_MAX = (WARMUP_CYCLES > TAIL_CYCLES) ? WARMUP_CYCLES : TAIL_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    tx_state_e       state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            last_q, last_d;
    logic            ready_c, load, emit, err_d, oen_d, d0_d, d1_d;
    logic            sh_d0, sh_d1, pair_last, par;

    ddr_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .emit      (emit),
        .load_data (s_data),
        .d0        (sh_d0),
        .d1        (sh_d1),
`ifdef DDR_TX_FRAMER_PARITY_EN
        .parity    (par),
`endif
        .pair_last (pair_last)
    );

`ifndef DDR_TX_FRAMER_PARITY_EN
    assign par = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        last_d  = last_q;
        ready_c = 1'b0;
        load    = 1'b0;
        emit    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (s_valid) begin
                    load    = 1'b1;
                    last_d  = s_last;
                    state_d = WARMUP;
                end
            end
            WARMUP: begin
                if (ph_q == PH_W'(WARMUP_CYCLES - 1)) begin
                    state_d = DATA;
                    emit    = 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            DATA: begin
                if (!pair_last) begin
                    emit = 1'b1;
                end else if (!last_q) begin
                    ready_c = 1'b1;
                    if (s_valid) begin
                        load   = 1'b1;
                        emit   = 1'b1;
                        last_d = s_last;
                    end else begin
                        err_d   = 1'b1;
                        state_d = TAIL;
                    end
                end else begin
`ifdef DDR_TX_FRAMER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = TAIL;
`endif
                end
            end
`ifdef DDR_TX_FRAMER_PARITY_EN
            PARITY: state_d = TAIL;
`endif
            TAIL: begin
                if (ph_q == PH_W'(TAIL_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            ph_d = '0;
        end

        // Output registers are loaded with the values belonging to the state being entered.
        oen_d = (state_d == IDLE);
        d0_d  = 1'b0;
        d1_d  = 1'b0;
        case (state_d)
            WARMUP: d1_d = 1'b1;
            DATA: begin
                d0_d = sh_d0;
                d1_d = sh_d1;
            end
            PARITY: begin
                d0_d = par;
                d1_d = ~par;
            end
            default: ;
        endcase
    end

    assign s_ready = ready_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ph_q         <= '0;
            last_q       <= 1'b0;
            d0           <= 1'b0;
            d1           <= 1'b0;
            oen          <= 1'b1;
            busy         <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            last_q       <= last_d;
            d0           <= d0_d;
            d1           <= d1_d;
            oen          <= oen_d;
            busy         <= (state_d != IDLE);
            err_underrun <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr_tx_framer.sv
// Directed, table-driven bench for ddr_tx_framer (default parameters, either parity build).
module tb_ddr_tx_framer;

`ifdef DDR_TX_FRAMER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready, d0, d1, oen, busy, err_underrun;

    ddr_tx_framer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .d0           (d0),
        .d1           (d1),
        .oen          (oen),
        .busy         (busy),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    // exp = {s_ready, d0, d1, oen, busy, err_underrun} during the cycle the inputs are applied.
    typedef struct {
        logic       v;
        logic [7:0] data;
        logic       last;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] E_IDLE = 6'b100100;
    localparam logic [5:0] E_WARM = 6'b001010;
    localparam logic [5:0] E_TAIL = 6'b000010;
    localparam logic [5:0] E_RST  = 6'b000100;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {rdy,d0,d1,oen,busy,err}=%b, expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic l,
                                input logic [5:0] e);
        tbl.push_back('{v: v, data: d, last: l, exp: e});
    endfunction

    function automatic void add_tx(input logic [7:0] d, input logic l);
        add(1'b1, d, l, E_IDLE);
    endfunction

    function automatic void add_warm(input logic v, input logic [7:0] d, input logic l);
        for (int i = 0; i < 4; i++) add(v, d, l, E_WARM);
    endfunction

    function automatic void add_word(input logic [7:0] w, input logic v, input logic [7:0] d,
                                     input logic l, input logic rdy_last);
        for (int i = 0; i < 4; i++) begin
            add(v, d, l, {(i == 3) && rdy_last, w[2*i], w[2*i+1], 3'b010});
        end
    endfunction

    // p: XOR of all data bits of the frame; under: frame aborted by underrun.
    function automatic void add_end(input logic p, input logic under);
        if (PAR && !under) add(1'b0, 8'h00, 1'b0, {1'b0, p, ~p, 3'b010});
        add(1'b0, 8'h00, 1'b0, {5'b00001, 1'b0} | {5'b0, under});
        add(1'b0, 8'h00, 1'b0, E_TAIL);
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            s_valid = tbl[i].v;
            s_data  = tbl[i].data;
            s_last  = tbl[i].last;
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), {s_ready, d0, d1, oen, busy, err_underrun},
                tbl[i].exp);
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", {s_ready, d0, d1, oen, busy, err_underrun}, E_RST);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;

        // Idle, single word, back-to-back pair, underrun, odd-parity word.
        add(1'b0, 8'h00, 1'b0, E_IDLE);
        add_tx(8'hA5, 1'b1);
        add_warm(1'b0, 8'h00, 1'b0);
        add_word(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
        add_end(1'b0, 1'b0);
        add_tx(8'h01, 1'b0);
        add_warm(1'b1, 8'h80, 1'b1);
        add_word(8'h01, 1'b1, 8'h80, 1'b1, 1'b1);
        add_word(8'h80, 1'b0, 8'h00, 1'b0, 1'b0);
        add_end(1'b0, 1'b0);
        add_tx(8'h3C, 1'b0);
        add_warm(1'b0, 8'h00, 1'b0);
        add_word(8'h3C, 1'b0, 8'h00, 1'b0, 1'b1);
        add_end(1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, E_IDLE);
        add_tx(8'h07, 1'b1);
        add_warm(1'b0, 8'h00, 1'b0);
        add_word(8'h07, 1'b0, 8'h00, 1'b0, 1'b0);
        add_end(1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, E_IDLE);
        run_table("seq");

        // Reset while the third pair of 0xA5 is on the pins.
        add_tx(8'hA5, 1'b1);
        add_warm(1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b0, 6'b010010);
        add(1'b0, 8'h00, 1'b0, 6'b010010);
        run_table("pre_rst");
        chk("pair3_before_rst", {s_ready, d0, d1, oen, busy, err_underrun}, 6'b001010);
        rst_n = 1'b0;
        #1;
        chk("mid_reset", {s_ready, d0, d1, oen, busy, err_underrun}, E_RST);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add(1'b0, 8'h00, 1'b0, E_IDLE);
        add_tx(8'hA5, 1'b1);
        add_warm(1'b0, 8'h00, 1'b0);
        add_word(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
        add_end(1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, E_IDLE);
        run_table("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
